// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with memory-wait timeout trap.
// Optional performance counters are enabled by defining MULTICYCLE_PERF_EN.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_re,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        trap,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
);

  // state  | meaning
  // FETCH  | request instruction, wait for imem_ready
  // DECODE | latch opcode, classify legal/system/illegal
  // EXEC   | branches resolve and retire here
  // MEM    | load/store access, wait for dmem_ready
  // WB     | register write-back and PC update, retire
  // HALT   | SYSTEM instruction reached, terminal
  // TRAP   | illegal opcode or memory timeout, terminal
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Last wait cycle index; a ready seen in this cycle still completes the access.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic [6:0] opcode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= 8'd0;
      opcode_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    imem_re = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 2'd0;
    reg_we  = 1'b0;
    wb_sel  = 2'd0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    halted  = 1'b0;
    trap    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_re = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
          wait_d  = 8'd0;
        end else if (wait_cnt == TMO_LAST) begin
          state_d = S_TRAP;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_EXEC;
          OP_SYSTEM:                         state_d = S_HALT;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (opcode_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_re = (opcode_q == OP_LOAD);
        dmem_we = (opcode_q != OP_LOAD);
        if (dmem_ready) begin
          wait_d = 8'd0;
          if (opcode_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_cnt == TMO_LAST) begin
          state_d = S_TRAP;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (opcode_q)
          OP_JAL:  begin pc_sel = 2'd1; wb_sel = 2'd2; end
          OP_JALR: begin pc_sel = 2'd2; wb_sel = 2'd2; end
          OP_LOAD: wb_sel = 2'd1;
          OP_LUI:  wb_sel = 2'd3;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: state_d = S_TRAP;
    endcase
    // Reset abandons the instruction in flight: nothing commits in the reset cycle.
    if (reset) begin
      imem_re = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_sel  = 2'd0;
      reg_we  = 1'b0;
      wb_sel  = 2'd0;
      dmem_re = 1'b0;
      dmem_we = 1'b0;
      halted  = 1'b0;
      trap    = 1'b0;
    end
  end

  assign state = state_q;

`ifdef MULTICYCLE_PERF_EN
  logic        retire;
  logic [31:0] cycle_q, instret_q;

  assign retire = ((state_q == S_EXEC) && (opcode_q == OP_BRANCH)) ||
                  ((state_q == S_MEM) && (opcode_q == OP_STORE) && dmem_ready) ||
                  (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if ((state_q != S_HALT) && (state_q != S_TRAP)) cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = 32'd0;
  assign instret   = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand sequences for timeout/halt/reset cases.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_re, ir_we, pc_we, reg_we, dmem_re, dmem_we, halted, trap;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_re(imem_re),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .dmem_re(dmem_re), .dmem_we(dmem_we), .state(state),
    .halted(halted), .trap(trap), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R  = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, SYS = 7'b1110011, BAD = 7'b1111111;

  // expected = {state, imem_re, ir_we, pc_we, pc_sel, reg_we, wb_sel, dmem_re, dmem_we, halted, trap}
  typedef struct {
    logic [6:0]  op;
    logic        bt, ir, dr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] o(input logic [2:0] st, input logic ire, input logic irw,
                                    input logic pcw, input logic [1:0] pcs, input logic rw,
                                    input logic [1:0] wbs, input logic dre, input logic dwe,
                                    input logic h, input logic t);
    return {st, ire, irw, pcw, pcs, rw, wbs, dre, dwe, h, t};
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef MULTICYCLE_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic add(input logic [6:0] op, input logic bt, input logic ir, input logic dr,
                     input logic [14:0] exp);
    vec_t v;
    v.op = op; v.bt = bt; v.ir = ir; v.dr = dr; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] op, input logic bt,
                       input logic ir, input logic dr);
    @(negedge clk);
    reset = rst; opcode = op; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  function automatic logic [14:0] outs();
    return {state, imem_re, ir_we, pc_we, pc_sel, reg_we, wb_sel, dmem_re, dmem_we, halted, trap};
  endfunction

  task automatic do_reset();
    drive(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // FETCH(ready), DECODE(op), EXEC -> leaves the FSM entering the state after EXEC
  task automatic to_exec(input logic [6:0] op);
    drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, op,   1'b0, 1'b0, 1'b0);
    drive(1'b0, op,   1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n, nwe;
    reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

    // R-type
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(R,    0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(R,    0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(R,    0, 0, 0, o(4, 0,0,1,0,1,0,0,0,0,0));
    // LOAD, dmem_ready on 4th MEM cycle
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(LD,   0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(LD,   0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(LD,   0, 0, 0, o(3, 0,0,0,0,0,0,1,0,0,0));
    add(LD,   0, 0, 0, o(3, 0,0,0,0,0,0,1,0,0,0));
    add(LD,   0, 0, 0, o(3, 0,0,0,0,0,0,1,0,0,0));
    add(LD,   0, 0, 1, o(3, 0,0,0,0,0,0,1,0,0,0));
    add(LD,   0, 0, 0, o(4, 0,0,1,0,1,1,0,0,0,0));
    // BRANCH taken, with two fetch wait cycles
    add(7'd0, 0, 0, 0, o(0, 1,0,0,0,0,0,0,0,0,0));
    add(7'd0, 0, 0, 0, o(0, 1,0,0,0,0,0,0,0,0,0));
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(BR,   0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(BR,   1, 0, 0, o(2, 0,0,1,1,0,0,0,0,0,0));
    // BRANCH not taken
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(BR,   0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(BR,   0, 0, 0, o(2, 0,0,1,0,0,0,0,0,0,0));
    // JAL
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(JAL,  0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(JAL,  0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(JAL,  0, 0, 0, o(4, 0,0,1,1,1,2,0,0,0,0));
    // JALR
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(JALR, 0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(JALR, 0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(JALR, 0, 0, 0, o(4, 0,0,1,2,1,2,0,0,0,0));
    // LUI
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(LUI,  0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(LUI,  0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(LUI,  0, 0, 0, o(4, 0,0,1,0,1,3,0,0,0,0));
    // STORE completing on 2nd MEM cycle
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(ST,   0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(ST,   0, 0, 0, o(2, 0,0,0,0,0,0,0,0,0,0));
    add(ST,   0, 0, 0, o(3, 0,0,0,0,0,0,0,1,0,0));
    add(ST,   0, 0, 1, o(3, 0,0,1,0,0,0,0,1,0,0));
    // illegal opcode -> TRAP, terminal
    add(7'd0, 0, 1, 0, o(0, 1,1,0,0,0,0,0,0,0,0));
    add(BAD,  0, 0, 0, o(1, 0,0,0,0,0,0,0,0,0,0));
    add(R,    0, 1, 1, o(6, 0,0,0,0,0,0,0,0,0,1));
    add(R,    0, 1, 1, o(6, 0,0,0,0,0,0,0,0,0,1));

    // reset cycle itself: everything quiet
    drive(1'b1, 7'd0, 1'b0, 1'b1, 1'b1);
    check("reset_outputs", 32'(outs() & 15'h0fff), 32'd0);
    drive(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b0, tbl[i].op, tbl[i].bt, tbl[i].ir, tbl[i].dr);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // counters over one R-type, then HALT freezes cycle_cnt
    do_reset();
    check("cnt_after_reset", cycle_cnt | instret, 32'd0);
    to_exec(R);
    drive(1'b0, R, 1'b0, 1'b0, 1'b0);
    check("wb_state", 32'(state), 32'd4);
    drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    check("rtype_cycle_cnt", cycle_cnt, perf(32'd4));
    check("rtype_instret", instret, perf(32'd1));
    drive(1'b0, SYS, 1'b0, 1'b0, 1'b0);
    drive(1'b0, SYS, 1'b0, 1'b1, 1'b1);
    check("halt_state", {29'd0, state}, 32'd5);
    check("halted", 32'(halted), 32'd1);
    check("halt_cycle_cnt", cycle_cnt, perf(32'd6));
    repeat (5) drive(1'b0, SYS, 1'b0, 1'b1, 1'b1);
    check("halt_frozen_cycle_cnt", cycle_cnt, perf(32'd6));
    check("halt_frozen_instret", instret, perf(32'd1));
    check("halt_no_imem_re", 32'(imem_re), 32'd0);

    // STORE timeout in MEM
    do_reset();
    to_exec(ST);
    n = 0; nwe = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, ST, 1'b0, 1'b0, 1'b0);
      if (state != 3'd3) break;
      n++;
      if (dmem_we) nwe++;
    end
    check("mem_timeout_cycles", 32'(n), 32'd15);
    check("mem_timeout_we_cycles", 32'(nwe), 32'd15);
    check("mem_timeout_state", 32'(state), 32'd6);
    check("mem_timeout_trap", 32'(trap), 32'd1);
    drive(1'b0, ST, 1'b0, 1'b0, 1'b0);
    check("trap_dmem_we", 32'(dmem_we), 32'd0);

    // FETCH timeout
    do_reset();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
      if (state != 3'd0) break;
      n++;
    end
    check("fetch_timeout_cycles", 32'(n), 32'd15);
    check("fetch_timeout_state", 32'(state), 32'd6);

    // ready on the last allowed cycle wins over timeout
    do_reset();
    repeat (14) drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    check("last_cycle_ir_we", 32'(ir_we), 32'd1);
    drive(1'b0, R, 1'b0, 1'b0, 1'b0);
    check("last_cycle_decode", 32'(state), 32'd1);

    // reset while a STORE waits in MEM
    do_reset();
    to_exec(ST);
    drive(1'b0, ST, 1'b0, 1'b0, 1'b0);
    check("store_in_mem", 32'(state), 32'd3);
    drive(1'b1, ST, 1'b0, 1'b0, 1'b1);
    check("reset_mem_no_commit", 32'({pc_we, reg_we, dmem_we, dmem_re}), 32'd0);
    drive(1'b0, ST, 1'b0, 1'b0, 1'b0);
    check("reset_mem_state", 32'(state), 32'd0);
    check("reset_mem_strobes", 32'({ir_we, pc_we, reg_we, dmem_re, dmem_we, halted, trap}), 32'd0);
    check("reset_mem_counters", cycle_cnt | instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
